// File: rtl/arcade_pkg.sv
// Types and constants shared by the quadrature emitter and the spinwheel decoder,
// so that both ends agree on the phase sequence and the direction encoding.
package arcade_pkg;

  typedef logic [1:0] quad_phase_t;

  typedef enum logic {
    QDIR_FWD = 1'b0,
    QDIR_REV = 1'b1
  } quad_dir_t;

  typedef enum logic {
    QTX_IDLE = 1'b0,
    QTX_RUN  = 1'b1
  } quad_tx_state_t;

  // Phase index -> {A,B}; forward rotation walks 0,1,2,3 so that A leads B
  localparam logic [3:0][1:0] QUAD_AB = {2'b01, 2'b11, 2'b10, 2'b00};

  function automatic quad_phase_t quad_step(quad_phase_t p, quad_dir_t dir);
    return (dir == QDIR_FWD) ? quad_phase_t'(p + 2'd1) : quad_phase_t'(p - 2'd1);
  endfunction

endpackage

// File: rtl/arcade_tick_div.sv
// Rate divider: counts 0..DIV-1 while enabled and flags the terminal count.
// A clear holds the count at zero and suppresses the terminal-count pulse.
module arcade_tick_div #(
  parameter int DIV_W = 24,
  parameter int DIV   = 100000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [DIV_W-1:0] TERM = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && !clr_i && (cnt_q == TERM);

endmodule

// File: rtl/quad_encoder_tx.sv
// Quadrature encoder emitter: turns a signed step command into that many A/B
// transitions, one every STEP_DIV clocks, with both phases driven from flops.
module quad_encoder_tx
  import arcade_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int STEP_DIV = 100000,
  parameter int DIV_W    = 24
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [CNT_W-1:0] cmd_steps,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        steps_left,
  output logic                    enc_a,
  output logic                    enc_b
);

  quad_tx_state_t   state_q, state_d;
  quad_phase_t      p_q, p_d;
  quad_dir_t        dir_q, dir_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             done_q, done_d;
  logic [1:0]       ab_q, ab_d;

  logic             accept;
  logic             tick;
  logic [CNT_W-1:0] cmd_raw;
  logic [CNT_W-1:0] cmd_mag;

  assign accept  = cmd_valid && (state_q == QTX_IDLE);
  assign cmd_raw = cmd_steps;
  // Two's-complement negate keeps the most negative value as 2^(CNT_W-1) unsigned
  assign cmd_mag = cmd_raw[CNT_W-1] ? (~cmd_raw + CNT_W'(1)) : cmd_raw;

  arcade_tick_div #(
    .DIV_W(DIV_W),
    .DIV  (STEP_DIV)
  ) u_tick_div (
    .clk   (clk),
    .resetn(resetn),
    .clr_i (state_q != QTX_RUN),
    .en_i  (state_q == QTX_RUN),
    .tc_o  (tick)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= QTX_IDLE;
      p_q     <= '0;
      dir_q   <= QDIR_FWD;
      steps_q <= '0;
      done_q  <= 1'b0;
      ab_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      dir_q   <= dir_d;
      steps_q <= steps_d;
      done_q  <= done_d;
      ab_q    <= ab_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      QTX_IDLE: if (accept && (cmd_raw != '0)) state_d = QTX_RUN;
      QTX_RUN: begin
        if (abort) begin
          state_d = QTX_IDLE;
        end else if (tick && (steps_q == CNT_W'(1))) begin
          state_d = QTX_IDLE;
        end
      end
      default: state_d = QTX_IDLE;
    endcase
  end

  // Abort takes priority over a coincident terminal count, so no step is emitted
  always_comb begin
    p_d     = p_q;
    dir_d   = dir_q;
    steps_d = steps_q;
    done_d  = 1'b0;
    if (state_q == QTX_IDLE) begin
      if (accept) begin
        if (cmd_raw == '0) begin
          done_d = 1'b1;
        end else begin
          dir_d   = cmd_raw[CNT_W-1] ? QDIR_REV : QDIR_FWD;
          steps_d = cmd_mag;
        end
      end
    end else if (abort) begin
      steps_d = '0;
      done_d  = 1'b1;
    end else if (tick) begin
      p_d     = quad_step(p_q, dir_q);
      steps_d = steps_q - CNT_W'(1);
      done_d  = (steps_q == CNT_W'(1));
    end
    ab_d = QUAD_AB[p_d];
  end

  always_comb begin
    cmd_ready  = (state_q == QTX_IDLE);
    busy       = (state_q == QTX_RUN);
    done       = done_q;
    steps_left = steps_q;
    enc_a      = ab_q[1];
    enc_b      = ab_q[0];
  end

endmodule
